// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: packet layout, widths and default requester count.
// Imported by the arbiter, its interface, and downstream ROB/RS consumers.
package cdb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int CDB_NUM_REQ = 4;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        data;
        logic [XLEN-1:0]        target_pc;
        logic                   mispredict;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side payload bundle plus the registered CDB broadcast.
// master = functional units side, slave = arbiter side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
);
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0] req_rob_tag;
    logic [NUM_REQ-1:0][XLEN-1:0]        req_data;
    logic [NUM_REQ-1:0][XLEN-1:0]        req_target_pc;
    logic [NUM_REQ-1:0]                  req_mispredict;
    logic [NUM_REQ-1:0]                  grant;

    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_rob_tag;
    logic [XLEN-1:0]        cdb_data;
    logic [XLEN-1:0]        cdb_target_pc;
    logic                   cdb_mispredict;

    modport master (
        output req, req_rob_tag, req_data, req_target_pc, req_mispredict,
        input  grant, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
    );

    modport slave (
        input  req, req_rob_tag, req_data, req_target_pc, req_mispredict,
        output grant, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
    );
endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Find-first-set starting at ptr with wrap; one-hot grant plus winner index.
// Latency: combinational. Backpressure: none, pure selection logic.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_LEN = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_LEN-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_LEN-1:0] o_idx,
    output logic               o_found
);
    int                 ci;
    logic [PTR_LEN-1:0] w_pos;

    // Explicit wrap instead of modulo so non-power-of-two NUM_REQ works.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        ci      = 0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ci = int'(i_ptr) + k;
            if (ci >= NUM_REQ) ci = ci - NUM_REQ;
            w_pos = PTR_LEN'(ci);
            if (!o_found && i_req[w_pos]) begin
                o_found        = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter (optional CDB_MISPREDICT_PRIORITY_EN); grant same cycle, broadcast next cycle.
// Backpressure: requesters hold req/payload until granted; flush squashes the grant.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int PTR_LEN = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    logic [PTR_LEN-1:0] r_rr_ptr;
    CDB_PACKET          r_pkt;

    logic [NUM_REQ-1:0] w_rr_grant;
    logic [PTR_LEN-1:0] w_rr_idx;
    logic               w_rr_found;
    logic [NUM_REQ-1:0] w_sel_grant;
    logic [PTR_LEN-1:0] w_sel_idx;
    logic               w_sel_found;
    logic               w_win_vld;
    logic [PTR_LEN-1:0] w_next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_LEN (PTR_LEN)
    ) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

`ifdef CDB_MISPREDICT_PRIORITY_EN
    logic [NUM_REQ-1:0] w_mp_req;
    logic [NUM_REQ-1:0] w_mp_grant;
    logic [PTR_LEN-1:0] w_mp_idx;
    logic               w_mp_found;

    assign w_mp_req   = bus.req & bus.req_mispredict;
    assign w_mp_grant = w_mp_req & (~w_mp_req + NUM_REQ'(1));
    assign w_mp_found = |w_mp_req;

    // Descending scan so the lowest mispredicting index is the last one written.
    always_comb begin
        w_mp_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_mp_req[i]) w_mp_idx = PTR_LEN'(i);
        end
    end

    assign w_sel_grant = w_mp_found ? w_mp_grant : w_rr_grant;
    assign w_sel_idx   = w_mp_found ? w_mp_idx   : w_rr_idx;
    assign w_sel_found = w_mp_found | w_rr_found;
`else
    assign w_sel_grant = w_rr_grant;
    assign w_sel_idx   = w_rr_idx;
    assign w_sel_found = w_rr_found;
`endif

    assign w_win_vld  = w_sel_found & ~flush & reset_n;
    assign w_next_ptr = (w_sel_idx == PTR_LEN'(NUM_REQ - 1)) ? '0 : w_sel_idx + PTR_LEN'(1);
    assign bus.grant  = w_win_vld ? w_sel_grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_pkt    <= '0;
        end else if (w_win_vld) begin
            r_rr_ptr        <= w_next_ptr;
            r_pkt.valid     <= 1'b1;
            r_pkt.rob_tag   <= bus.req_rob_tag[w_sel_idx];
            r_pkt.data      <= bus.req_data[w_sel_idx];
            r_pkt.target_pc <= bus.req_target_pc[w_sel_idx];
            r_pkt.mispredict <= bus.req_mispredict[w_sel_idx];
        end else begin
            r_pkt.valid <= 1'b0;
        end
    end

    assign bus.cdb_valid      = r_pkt.valid;
    assign bus.cdb_rob_tag    = r_pkt.rob_tag;
    assign bus.cdb_data       = r_pkt.data;
    assign bus.cdb_target_pc  = r_pkt.target_pc;
    assign bus.cdb_mispredict = r_pkt.mispredict;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin order, wrap, flush, async reset, mispredict handling.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;
    int   n_checks;
    int   n_errors;

    cdb_arbiter_if #(.NUM_REQ(4)) bus ();

    cdb_arbiter #(.NUM_REQ(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_payload();
        for (int i = 0; i < 4; i++) begin
            bus.req_rob_tag[i]    = ROB_TAG_LEN'(i + 1);
            bus.req_data[i]       = 32'h100 + 32'(i);
            bus.req_target_pc[i]  = 32'h1000 + 32'(4 * i);
            bus.req_mispredict[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush   = 1'b0;
        bus.req = 4'b0000;
        init_payload();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
        n_checks++; if (bus.cdb_rob_tag !== '0) begin n_errors++; $display("FAIL reset_tag: got %0d want 0", bus.cdb_rob_tag); end
        n_checks++; if (bus.cdb_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", bus.cdb_data); end
        n_checks++; if (bus.cdb_target_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", bus.cdb_target_pc); end
        n_checks++; if (bus.cdb_mispredict !== 1'b0) begin n_errors++; $display("FAIL reset_mp: got %b want 0", bus.cdb_mispredict); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL idle_grant: got %b want 0000", bus.grant); end
    endtask

    // rr_ptr starts at 0; four all-request cycles visit 0,1,2,3 and return the pointer to 0.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        bus.req = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            n_checks++; if (bus.grant !== exp_g) begin n_errors++; $display("FAIL rr_grant%0d: got %b want %b", k, bus.grant, exp_g); end
            tick();
            n_checks++; if (bus.cdb_valid !== 1'b1) begin n_errors++; $display("FAIL rr_valid%0d: got %b want 1", k, bus.cdb_valid); end
            n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(k + 1)) begin n_errors++; $display("FAIL rr_tag%0d: got %0d want %0d", k, bus.cdb_rob_tag, k + 1); end
            n_checks++; if (bus.cdb_data !== 32'h100 + 32'(k)) begin n_errors++; $display("FAIL rr_data%0d: got %h want %h", k, bus.cdb_data, 32'h100 + 32'(k)); end
        end
        n_checks++; if (bus.cdb_target_pc !== 32'h100C) begin n_errors++; $display("FAIL rr_pc3: got %h want 100c", bus.cdb_target_pc); end
        bus.req = 4'b0000;
        tick();
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_errors++; $display("FAIL rr_idle_valid: got %b want 0", bus.cdb_valid); end
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(4)) begin n_errors++; $display("FAIL rr_hold_tag: got %0d want 4", bus.cdb_rob_tag); end
    endtask

    task automatic test_wrap();
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0101;
        #1;
        n_checks++; if (bus.grant !== 4'b0001) begin n_errors++; $display("FAIL wrap_grant_a: got %b want 0001", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(1)) begin n_errors++; $display("FAIL wrap_tag_a: got %0d want 1", bus.cdb_rob_tag); end
        n_checks++; if (bus.grant !== 4'b0100) begin n_errors++; $display("FAIL wrap_grant_b: got %b want 0100", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(3)) begin n_errors++; $display("FAIL wrap_tag_b: got %0d want 3", bus.cdb_rob_tag); end
        bus.req = 4'b1001;
        #1;
        n_checks++; if (bus.grant !== 4'b1000) begin n_errors++; $display("FAIL wrap_ptr3: got %b want 1000", bus.grant); end
        tick();
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_flush();
        bus.req_rob_tag[2] = ROB_TAG_LEN'(5);
        bus.req_data[2]    = 32'hDEADBEEF;
        bus.req = 4'b0100;
        #1;
        n_checks++; if (bus.grant !== 4'b0100) begin n_errors++; $display("FAIL flush_pre_grant: got %b want 0100", bus.grant); end
        tick();
        flush   = 1'b1;
        bus.req = 4'b0011;
        #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL flush_grant: got %b want 0000", bus.grant); end
        n_checks++; if (bus.cdb_valid !== 1'b1) begin n_errors++; $display("FAIL flush_bcast_valid: got %b want 1", bus.cdb_valid); end
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(5)) begin n_errors++; $display("FAIL flush_bcast_tag: got %0d want 5", bus.cdb_rob_tag); end
        n_checks++; if (bus.cdb_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL flush_bcast_data: got %h want deadbeef", bus.cdb_data); end
        tick();
        flush   = 1'b0;
        bus.req = 4'b0000;
        #1;
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_errors++; $display("FAIL flush_after_valid: got %b want 0", bus.cdb_valid); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL flush_after_grant: got %b want 0000", bus.grant); end
        // Pointer must still be 3 after the squashed cycle, so 0011 wraps to unit 0.
        bus.req = 4'b0011;
        #1;
        n_checks++; if (bus.grant !== 4'b0001) begin n_errors++; $display("FAIL flush_ptr_kept: got %b want 0001", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(1)) begin n_errors++; $display("FAIL flush_resume_tag: got %0d want 1", bus.cdb_rob_tag); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        bus.req = 4'b0100;
        tick();
        n_checks++; if (bus.cdb_valid !== 1'b1) begin n_errors++; $display("FAIL arst_pre_valid: got %b want 1", bus.cdb_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %b want 0", bus.cdb_valid); end
        n_checks++; if (bus.cdb_rob_tag !== '0) begin n_errors++; $display("FAIL arst_tag: got %0d want 0", bus.cdb_rob_tag); end
        n_checks++; if (bus.cdb_data !== 32'h0) begin n_errors++; $display("FAIL arst_data: got %h want 0", bus.cdb_data); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_errors++; $display("FAIL arst_grant: got %b want 0000", bus.grant); end
        @(negedge clk);
        reset_n = 1'b1;
        bus.req = 4'b1010;
        #1;
        n_checks++; if (bus.grant !== 4'b0010) begin n_errors++; $display("FAIL arst_ptr0: got %b want 0010", bus.grant); end
        bus.req = 4'b1000;
        #1;
        n_checks++; if (bus.grant !== 4'b1000) begin n_errors++; $display("FAIL arst_grant3: got %b want 1000", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(4)) begin n_errors++; $display("FAIL arst_resume_tag: got %0d want 4", bus.cdb_rob_tag); end
        bus.req = 4'b0000;
        tick();
    endtask

    // Pointer is 0 here; unit 1 carries the mispredict flag.
    task automatic test_mispredict();
        bus.req_mispredict = 4'b0010;
        bus.req = 4'b0011;
        #1;
`ifdef CDB_MISPREDICT_PRIORITY_EN
        n_checks++; if (bus.grant !== 4'b0010) begin n_errors++; $display("FAIL mp_grant: got %b want 0010", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_mispredict !== 1'b1) begin n_errors++; $display("FAIL mp_flag: got %b want 1", bus.cdb_mispredict); end
        n_checks++; if (bus.cdb_rob_tag !== ROB_TAG_LEN'(2)) begin n_errors++; $display("FAIL mp_tag: got %0d want 2", bus.cdb_rob_tag); end
`else
        n_checks++; if (bus.grant !== 4'b0001) begin n_errors++; $display("FAIL mp_grant: got %b want 0001", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_mispredict !== 1'b0) begin n_errors++; $display("FAIL mp_flag: got %b want 0", bus.cdb_mispredict); end
        n_checks++; if (bus.grant !== 4'b0010) begin n_errors++; $display("FAIL mp_next_grant: got %b want 0010", bus.grant); end
        tick();
        n_checks++; if (bus.cdb_mispredict !== 1'b1) begin n_errors++; $display("FAIL mp_payload: got %b want 1", bus.cdb_mispredict); end
`endif
        bus.req = 4'b0000;
        bus.req_mispredict = 4'b0000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_flush();
        test_async_reset();
        test_mispredict();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single Common Data Bus between completing functional units. Each cycle it picks at most one requesting unit, issues a same-cycle grant, and drives the winner's result on a registered CDB broadcast one cycle later. The broadcast feeds the reorder buffer's writeback port and the reservation stations. A ROB flush squashes the arbitration.

## Interface
- NUM_REQ, 4, number of requesting functional units (≥2; need not be a power of two)
- PTR_LEN, $clog2(NUM_REQ), width of the round-robin pointer
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  ROB mispredict flush; squashes arbitration this cycle
- req  input  NUM_REQ  per-unit result-ready request
- req_rob_tag  input  NUM_REQ×`ROB_TAG_LEN  per-unit destination ROB tag
- req_data  input  NUM_REQ×`XLEN  per-unit writeback value
- req_target_pc  input  NUM_REQ×`XLEN  per-unit resolved target PC
- req_mispredict  input  NUM_REQ  per-unit mispredict flag
- grant  output  NUM_REQ  one-hot (or zero) combinational grant
- cdb_valid  output  1  registered broadcast valid (drives the ROB's CDB-valid input)
- cdb_rob_tag  output  `ROB_TAG_LEN  registered broadcast tag
- cdb_data  output  `XLEN  registered broadcast data
- cdb_target_pc  output  `XLEN  registered broadcast target PC
- cdb_mispredict  output  1  registered broadcast mispredict

## Operation
- State: round-robin pointer rr_ptr (PTR_LEN bits); output packet register.
- Handshake: a unit raises req[i] with a stable payload and holds both until it samples grant[i]=1. On that edge it may drop req or present a new result.
- Selection: search from index rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …). The first i with req[i]=1 wins. grant is one-hot on the winner and zero if there are no requests.
- Pointer update: on a grant to g, rr_ptr ← (g+1) mod NUM_REQ, with an explicit wrap so g=NUM_REQ-1 yields 0. With no grant, rr_ptr is unchanged.
- Output register: on a grant, it captures {1, tag, data, target_pc, mispredict} of the winner. Otherwise it captures cdb_valid=0; other fields hold their last values.
- flush=1: grant is forced to 0 and cdb_valid←0 on the next edge. rr_ptr is unchanged and requesters keep their req. Per the ROB flush protocol, units clear their own req in the flush cycle.
- The arbiter never grants two units in one cycle and never drops a granted packet except under flush or reset.

## Timing
- Grant latency: 0 cycles (combinational from req, rr_ptr, flush).
- Broadcast latency: a grant in cycle N gives cdb_valid=1 with the winner's fields in cycle N+1.
- Throughput: one broadcast per cycle, back-to-back with no bubbles.
- Fairness: a continuously requesting unit is granted within NUM_REQ cycles.
- Reset (reset_n=0, asynchronous): rr_ptr=0, cdb_valid=0, cdb_rob_tag=0, cdb_data=0, cdb_target_pc=0, cdb_mispredict=0. grant=0 while reset_n=0.
- Reset mid-operation: the pending broadcast is lost and no grant is issued. After release, arbitration restarts from index 0.
- If flush and reset_n=0 occur together, reset dominates.

## Configuration
- Macro CDB_MISPREDICT_PRIORITY_EN.
- Defined: any requester with req[i]=1 and req_mispredict[i]=1 wins before the round-robin search. Ties go to the lowest index. rr_ptr still updates to (g+1) mod NUM_REQ.
- Undefined: pure round-robin; req_mispredict is payload only.

## Structure
- sys_defs.svh holds a shared CDB_PACKET typedef {valid, rob_tag, data, target_pc, mispredict}, reused by the ROB and the reservation stations. It also holds the CDB_NUM_REQ default constant.
- One sub-module, rr_priority_picker: a combinational find-first-from-pointer over a NUM_REQ vector, returning a one-hot grant and the winner index.

## Test plan
- After reset, NUM_REQ=4, req=4'b0000 → grant=0, cdb_valid=0, all outputs 0.
- req=4'b1111 held for 4 cycles, rr_ptr=0 → grants 0,1,2,3 in order. Each cycle's cdb_rob_tag equals the winner's tag, one cycle later.
- rr_ptr=3, req=4'b0101 → grant=4'b0001 (wrap); next cycle grant=4'b0100, then rr_ptr=3.
- Unit 2 granted with tag 5, data 0xDEADBEEF, flush asserted in the following cycle while req=4'b0011 → that cycle's broadcast shows tag 5; the next cycle shows cdb_valid=0 and grant=0.
- reset_n pulsed low asynchronously mid-cycle with cdb_valid=1 → outputs clear immediately. After release, req=4'b1000 → grant=4'b1000.
- With CDB_MISPREDICT_PRIORITY_EN defined, rr_ptr=0, req=4'b0011, req_mispredict=4'b0010 → grant=4'b0010, cdb_mispredict=1 next cycle.
